// File: rtl/cla_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the multi-word carry-lookahead sequencer:
//   - operation encodings on in_op
//   - FSM state type
//   - width of the reused lookahead slice
// ---------------------------------------------------------------------------
package cla_seq_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;  // executes as ADD

    localparam int unsigned SLICE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

endpackage

// File: rtl/cla8_slice.sv
// ---------------------------------------------------------------------------
// cla8_slice
// Combinational 8-bit carry-lookahead adder built from per-bit
// propagate/generate terms.
// Ports:
//   a[7:0], b[7:0] : addends
//   cin            : carry into bit 0
//   s[7:0]         : sum
//   c7             : carry into bit 7 (for signed overflow detection)
//   cout           : carry out of bit 7
// ---------------------------------------------------------------------------
module cla8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c7,
    output logic       cout
);

    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat OR of products: g[j] qualified by every propagate
    // above it, plus cin qualified by all propagates below the carry.
    always_comb begin
        logic acc;
        logic term;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < 8; i++) begin
            acc = 1'b0;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                acc = acc | term;
            end
            term = cin;
            for (int unsigned m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = acc | term;
        end
    end

    assign s    = p ^ c[7:0];
    assign c7   = c[7];
    assign cout = c[8];

endmodule

// File: rtl/cla_multiword_seq.sv
// ---------------------------------------------------------------------------
// cla_multiword_seq
// Performs a WORDS x 8-bit ADD / SUB / ADC by pushing one 8-bit chunk per
// clock (LSB first) through a single cla8_slice, rippling the carry through
// a register between chunks.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (ready only in IDLE)
//   in_op               : 00 ADD, 01 SUB (A-B), 10 ADC, 11 treated as ADD
//   in_a, in_b, in_cin  : operands and carry-in (cin used by ADC only)
//   out_valid/out_ready : result handshake
//   out_sum             : W-bit result
//   out_cout            : carry out of MSB (SUB: 1 = no borrow)
//   out_ovf             : signed overflow
//   out_zero            : out_sum == 0
// Optional macro CLA_SEQ_SAT_EN: saturate out_sum on signed overflow.
// ---------------------------------------------------------------------------
module cla_multiword_seq
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int CNT_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [SLICE_W*WORDS-1:0]   in_a,
    input  logic [SLICE_W*WORDS-1:0]   in_b,
    input  logic                       in_cin,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*WORDS-1:0]   out_sum,
    output logic                       out_cout,
    output logic                       out_ovf,
    output logic                       out_zero
);

    localparam int unsigned W = SLICE_W * WORDS;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       sum_reg;
    logic               cout_reg;
    logic               ovf_reg;
    logic               zero_reg;

    logic [7:0]         a_chunk;
    logic [7:0]         b_chunk;
    logic [7:0]         s_chunk;
    logic               c7_s;
    logic               cout_s;
    logic               last;
    logic               ovf_now;
    logic [W-1:0]       sum_merged;
    logic [W-1:0]       sum_final;

    cla8_slice u_slice (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .s    (s_chunk),
        .c7   (c7_s),
        .cout (cout_s)
    );

    // Chunk selection and merge of the slice sum into the result image.
    always_comb begin
        a_chunk    = '0;
        b_chunk    = '0;
        sum_merged = sum_reg;
        for (int unsigned k = 0; k < WORDS; k++) begin
            if (cnt == CNT_W'(k)) begin
                a_chunk = a_reg[k*SLICE_W +: SLICE_W];
                b_chunk = b_reg[k*SLICE_W +: SLICE_W];
                sum_merged[k*SLICE_W +: SLICE_W] = s_chunk;
            end
        end
    end

    assign last    = (cnt == CNT_W'(WORDS - 1));
    assign ovf_now = c7_s ^ cout_s;

    always_comb begin
        sum_final = sum_merged;
`ifdef CLA_SEQ_SAT_EN
        if (last && ovf_now) begin
            sum_final = a_reg[W-1] ? {1'b1, {(W-1){1'b0}}}
                                   : {1'b0, {(W-1){1'b1}}};
        end
`endif
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
            zero_reg <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= in_a;
                        b_reg <= (in_op == OP_SUB) ? ~in_b : in_b;
                        cnt   <= '0;
                        case (in_op)
                            OP_SUB:  carry <= 1'b1;
                            OP_ADC:  carry <= in_cin;
                            default: carry <= 1'b0;
                        endcase
                    end
                end
                S_RUN: begin
                    sum_reg <= sum_final;
                    carry   <= cout_s;
                    if (last) begin
                        cout_reg <= cout_s;
                        ovf_reg  <= ovf_now;
                        zero_reg <= (sum_final == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = cout_reg;
    assign out_ovf  = ovf_reg;
    assign out_zero = zero_reg;

endmodule

// File: tb/tb_cla_multiword_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_multiword_seq
// Directed bench for cla_multiword_seq (WORDS=4). Expected results come from
// a wide-arithmetic reference model, queued at accept and compared when the
// DUT presents out_valid.
// ---------------------------------------------------------------------------
module tb_cla_multiword_seq;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int n_checks = 0;
    int n_pass   = 0;
    exp_t sb[$];

    cla_multiword_seq #(.WORDS(WORDS), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t       e;
        logic [W-1:0] bb;
        logic         c0;
        logic [W:0]   full;
        bb   = (op == 2'b01) ? ~b : b;
        c0   = (op == 2'b01) ? 1'b1 : ((op == 2'b10) ? cin : 1'b0);
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c0};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
`ifdef CLA_SEQ_SAT_EN
        if (e.ovf) e.sum = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        e.zero = (e.sum == '0);
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Present a request, wait (bounded) for acceptance, queue its expectation.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check("ready_before_issue", {{(W-1){1'b0}}, in_ready}, 1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        tick();
        sb.push_back(model(op, a, b, cin));
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and compare to queue head.
    task automatic wait_out(input string tag);
        int   n = 0;
        exp_t e;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, W'(n), W'(WORDS));
        check({tag, "_sb_nonempty"}, W'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb[0];
            check({tag, "_sum"},  out_sum, e.sum);
            check({tag, "_cout"}, W'(out_cout), W'(e.cout));
            check({tag, "_ovf"},  W'(out_ovf),  W'(e.ovf));
            check({tag, "_zero"}, W'(out_zero), W'(e.zero));
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, W'(out_valid), 0);
        if (sb.size() != 0) void'(sb.pop_front());
        out_ready = 1'b0;
    endtask

    initial begin
        logic   seen_valid;
        exp_t   held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", W'(out_valid), 0);
        check("rst_ready", W'(in_ready), 1);
        check("rst_sum",   out_sum, 0);
        check("rst_flags", W'({out_cout, out_ovf, out_zero}), 0);

        // Directed arithmetic cases
        issue(2'b00, 32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_out("add_ff_1");
        release_out("add_ff_1");

        issue(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_out("add_wrap");
        release_out("add_wrap");

        issue(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0);
        wait_out("sub_ovf");
        release_out("sub_ovf");

        issue(2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
        wait_out("adc_ovf");
        release_out("adc_ovf");

        issue(2'b11, 32'h1234_5678, 32'h1111_1111, 1'b1);
        wait_out("rsv_as_add");
        release_out("rsv_as_add");

        issue(2'b01, 32'h0000_0005, 32'h0000_0005, 1'b1);
        wait_out("sub_equal");
        release_out("sub_equal");

        issue(2'b00, 32'h0000_0001, 32'h0000_0002, 1'b1);
        wait_out("add_ignores_cin");
        release_out("add_ignores_cin");

        // Backpressure: hold DONE for 5 cycles while a new request is pending
        issue(2'b00, 32'h0102_0304, 32'h1020_3040, 1'b0);
        wait_out("bp");
        held      = sb[0];
        in_valid  = 1'b1;
        in_op     = 2'b01;
        in_a      = 32'h0000_1000;
        in_b      = 32'h0000_0001;
        in_cin    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", W'(out_valid), 1);
            check("bp_ready_low",  W'(in_ready), 0);
            check("bp_sum_stable", out_sum, held.sum);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", W'(out_valid), 0);
        check("bp_release_ready", W'(in_ready), 1);
        void'(sb.pop_front());
        out_ready = 1'b0;
        tick();   // pending request accepted on this edge
        sb.push_back(model(2'b01, 32'h0000_1000, 32'h0000_0001, 1'b0));
        in_valid = 1'b0;
        wait_out("bp_queued");
        release_out("bp_queued");

        // Reset while RUN is at chunk 2: operation discarded
        issue(2'b00, 32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        void'(sb.pop_back());
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", W'(in_ready), 1);
        check("mid_rst_valid", W'(out_valid), 0);
        check("mid_rst_sum",   out_sum, 0);
        check("mid_rst_flags", W'({out_cout, out_ovf, out_zero}), 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("mid_rst_no_output", W'(seen_valid), 0);
        issue(2'b00, 32'd5, 32'd7, 1'b0);
        wait_out("after_rst_add");
        check("after_rst_sum12", out_sum, 32'd12);
        release_out("after_rst_add");

        // Random operations
        for (int i = 0; i < 6; i++) begin
            issue(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
            wait_out("rand");
            release_out("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
